// File: rtl/mc_cpu_gen2.sv
// mc_cpu_gen2: parametrised multi-cycle CPU core (10-opcode, 32-bit ISA)
// sharing one instruction/data memory through a ready-handshaked port.
//
// Parameters: DATA_W (>=32), ADDR_W (1..12), REG_AW (register index width).
// Ports:
//   clk_in      clock, rising edge
//   reset_n     asynchronous active-low reset
//   data_in     memory read data (instruction in [31:0])
//   mem_ready   memory accepts/returns this cycle (sampled while mem_en=1)
//   data_out    store data
//   address     memory address
//   read_write  0 = read, 1 = write
//   mem_en      memory request
//   halted      core is in HALT
// Optional (macro PERF_CNT_EN): cycle_count, instr_count performance counters.
module mc_cpu_gen2 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              read_write,
  output logic              mem_en,
  output logic              halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LD  = 4'd1, OP_STR = 4'd2, OP_BRA = 4'd3,
    OP_XOR = 4'd4, OP_ADD = 4'd5, OP_ROT = 4'd6, OP_SHF = 4'd7,
    OP_HLT = 4'd8, OP_CMP = 4'd9
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, mdr_q, mdr_d, res_q, res_d;
  logic              taken_q, taken_d;
  logic              flag_c_q, flag_c_d, flag_p_q, flag_p_d, flag_e_q, flag_e_d;
  logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d, mem_en_q, mem_en_d, halted_q, halted_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] rf_q [2**REG_AW];
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  // Instruction field decode
  op_e               op;
  logic [REG_AW-1:0] src_idx, dst_idx;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [DATA_W-1:0] imm;
  logic [3:0]        cc;
  logic              unused_ir;

  assign op        = op_e'(ir_q[31:28]);
  assign cc        = ir_q[27:24];
  assign src_idx   = ir_q[12 +: REG_AW];
  assign dst_idx   = ir_q[0 +: REG_AW];
  assign src_addr  = ir_q[12 +: ADDR_W];
  assign dst_addr  = ir_q[0 +: ADDR_W];
  assign imm       = DATA_W'(ir_q[23:12]);
  assign unused_ir = ^ir_q[11:0];

  // ALU: result, carry, flag-update enable and branch decision from A/B
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_upd, br_taken;
  logic                sh_neg;
  logic [12:0]         sh_mag;
  logic [31:0]         rot_amt, rot_l;
  logic [2*DATA_W-1:0] rot_dbl;
  logic [DATA_W:0]     shf_w;

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_upd  = 1'b0;
    br_taken = 1'b0;
    // Shift amount is A[11:0] as signed; split into direction and magnitude.
    sh_neg   = a_q[11];
    sh_mag   = sh_neg ? (13'd4096 - {1'b0, a_q[11:0]}) : {1'b0, a_q[11:0]};
    rot_amt  = 32'(sh_mag) % DATA_W;
    // A right rotation is expressed as the equivalent left rotation.
    rot_l    = sh_neg ? ((DATA_W - rot_amt) % DATA_W) : rot_amt;
    rot_dbl  = {b_q, b_q} << rot_l;
    shf_w    = '0;
    case (op)
      OP_XOR: begin alu_res = a_q ^ b_q; alu_upd = 1'b1; end
      OP_ADD: begin {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q}; alu_upd = 1'b1; end
      OP_ROT: begin alu_res = rot_dbl[2*DATA_W-1 -: DATA_W]; alu_upd = 1'b1; end
      OP_SHF: begin
        // One guard bit past the shifted end captures the last bit shifted out.
        if (!sh_neg) begin
          shf_w   = {1'b0, b_q} << sh_mag;
          alu_res = shf_w[DATA_W-1:0];
          alu_c   = shf_w[DATA_W];
        end else begin
          shf_w   = {b_q, 1'b0} >> sh_mag;
          alu_res = shf_w[DATA_W:1];
          alu_c   = shf_w[0];
        end
        alu_upd = 1'b1;
      end
      OP_CMP: begin alu_res = ~a_q; alu_upd = 1'b1; end
      OP_BRA: begin
        case (cc)
          4'd0:    br_taken = 1'b1;
          4'd1:    br_taken = flag_p_q;
          4'd2:    br_taken = flag_e_q;
          4'd3:    br_taken = flag_c_q;
          4'd4:    br_taken = flag_n_q;
          4'd5:    br_taken = flag_z_q;
          4'd6:    br_taken = !flag_c_q;
          4'd7:    br_taken = !flag_n_q && !flag_z_q;
          default: br_taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    mdr_d      = mdr_q;
    res_d      = res_q;
    taken_d    = taken_q;
    flag_c_d   = flag_c_q;
    flag_p_d   = flag_p_q;
    flag_e_d   = flag_e_q;
    flag_n_d   = flag_n_q;
    flag_z_d   = flag_z_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    mem_en_d   = mem_en_q;
    data_out_d = data_out_q;
    halted_d   = halted_q;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d     = data_in[31:0];
          mem_en_d = 1'b0;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = ir_q[27] ? imm : rf_q[src_idx];
        b_d     = rf_q[dst_idx];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        res_d   = alu_res;
        taken_d = br_taken;
        if (alu_upd) begin
          flag_c_d = alu_c;
          flag_p_d = ^alu_res;
          flag_e_d = ~alu_res[0];
          flag_n_d = alu_res[DATA_W-1];
          flag_z_d = (alu_res == '0);
        end
        case (op)
          OP_LD: begin
            mem_en_d = 1'b1;
            rw_d     = 1'b0;
            addr_d   = src_addr;
            state_d  = S_MEMORY;
          end
          OP_STR: begin
            mem_en_d   = 1'b1;
            rw_d       = 1'b1;
            addr_d     = dst_addr;
            data_out_d = a_q;
            state_d    = S_MEMORY;
          end
          OP_HLT: begin
            mem_en_d = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (op == OP_LD) mdr_d = data_in;
          mem_en_d = 1'b0;
          state_d  = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        case (op)
          OP_LD: begin rf_we = 1'b1; rf_wdata = mdr_q; end
          OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: begin rf_we = 1'b1; rf_wdata = res_q; end
          default: ;
        endcase
        pc_d     = taken_q ? dst_addr : pc_q + ADDR_W'(1);
        addr_d   = pc_d;
        mem_en_d = 1'b1;
        rw_d     = 1'b0;
        state_d  = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mdr_q      <= '0;
      res_q      <= '0;
      taken_q    <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_p_q   <= 1'b0;
      flag_e_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      mem_en_q   <= 1'b1;
      data_out_q <= '0;
      halted_q   <= 1'b0;
      for (int unsigned i = 0; i < 2**REG_AW; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mdr_q      <= mdr_d;
      res_q      <= res_d;
      taken_q    <= taken_d;
      flag_c_q   <= flag_c_d;
      flag_p_q   <= flag_p_d;
      flag_e_q   <= flag_e_d;
      flag_n_q   <= flag_n_d;
      flag_z_q   <= flag_z_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      mem_en_q   <= mem_en_d;
      data_out_q <= data_out_d;
      halted_q   <= halted_d;
      if (rf_we) rf_q[dst_idx] <= rf_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign address    = addr_q;
  assign read_write = rw_q;
  assign mem_en     = mem_en_q;
  assign halted     = halted_q;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, ins_cnt_q, ins_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ins_cnt_d = ins_cnt_q;
    if (state_q != S_HALT) cyc_cnt_d = cyc_cnt_q + 32'd1;
    if (state_q == S_WRITEBACK || (state_q == S_EXECUTE && state_d == S_HALT))
      ins_cnt_d = ins_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt_q <= '0;
      ins_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ins_cnt_q <= ins_cnt_d;
    end
  end

  assign cycle_count = cyc_cnt_q;
  assign instr_count = ins_cnt_q;
`endif

endmodule

// File: tb/tb_mc_cpu_gen2.sv
module tb_mc_cpu_gen2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter core with a 4K x 32 memory
  logic        reset_n = 1'b0;
  logic        ready   = 1'b1;
  logic [31:0] data_in, data_out;
  logic [11:0] address;
  logic        rw, mem_en, halted;
  logic [31:0] mem [4096];
  int          wr_count = 0;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ins_cnt, cyc_cnt64, ins_cnt64;
`endif

  mc_cpu_gen2 dut (
    .clk_in(clk), .reset_n(reset_n), .data_in(data_in), .mem_ready(ready),
    .data_out(data_out), .address(address), .read_write(rw),
    .mem_en(mem_en), .halted(halted)
`ifdef PERF_CNT_EN
    , .cycle_count(cyc_cnt), .instr_count(ins_cnt)
`endif
  );

  assign data_in = mem[address];
  always @(posedge clk) begin
    if (reset_n && mem_en && rw && ready) begin
      mem[address] <= data_out;
      wr_count     <= wr_count + 1;
    end
  end

  // 64-bit / 8-bit address / 8-register core
  logic        reset64_n = 1'b0;
  logic [63:0] data_in64, data_out64;
  logic [7:0]  address64;
  logic        rw64, mem_en64, halted64;
  logic [63:0] mem64 [256];

  mc_cpu_gen2 #(.DATA_W(64), .ADDR_W(8), .REG_AW(3)) dut64 (
    .clk_in(clk), .reset_n(reset64_n), .data_in(data_in64), .mem_ready(1'b1),
    .data_out(data_out64), .address(address64), .read_write(rw64),
    .mem_en(mem_en64), .halted(halted64)
`ifdef PERF_CNT_EN
    , .cycle_count(cyc_cnt64), .instr_count(ins_cnt64)
`endif
  );

  assign data_in64 = mem64[address64];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    ready   = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    tick(2);
    wr_count = 0;
    reset_n  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(1);
    total_cnt++; if (mem_en !== 1'b1) $display("FAIL reset_mem_en got %0b exp 1", mem_en); else pass_cnt++;
    total_cnt++; if (rw !== 1'b0) $display("FAIL reset_rw got %0b exp 0", rw); else pass_cnt++;
    total_cnt++; if (address !== 12'h0) $display("FAIL reset_addr got %h exp 000", address); else pass_cnt++;
    total_cnt++; if (data_out !== 32'h0) $display("FAIL reset_data_out got %h exp 0", data_out); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got %0b exp 0", halted); else pass_cnt++;
  endtask

  task automatic test_add_halt();
    restart();
    mem[0] = 32'h58005003;  // ADD R3,#5
    mem[1] = 32'h80000000;  // HLT
    tick(6);
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_early got %0b exp 0", halted); else pass_cnt++;
    tick(1);
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_set got %0b exp 1", halted); else pass_cnt++;
    total_cnt++; if (dut.rf_q[3] !== 32'd5) $display("FAIL add_r3 got %h exp 5", dut.rf_q[3]); else pass_cnt++;
    total_cnt++; if (dut.flag_z_q !== 1'b0) $display("FAIL add_z got %0b exp 0", dut.flag_z_q); else pass_cnt++;
    tick(2);
    total_cnt++; if (halted !== 1'b1 || mem_en !== 1'b0)
      $display("FAIL halt_hold got halted=%0b mem_en=%0b exp 1/0", halted, mem_en); else pass_cnt++;
  endtask

  task automatic test_ld_branch();
    restart();
    mem[0]    = 32'h10010001;  // LD R1,[0x010]
    mem[1]    = 32'h58001001;  // ADD R1,#1
    mem[2]    = 32'h33000020;  // BRA C -> 0x020
    mem[12'h10] = 32'hFFFFFFFF;
    tick(5);
    total_cnt++; if (dut.rf_q[1] !== 32'hFFFFFFFF) $display("FAIL ld_r1 got %h exp ffffffff", dut.rf_q[1]); else pass_cnt++;
    tick(4);
    total_cnt++; if (dut.rf_q[1] !== 32'h0) $display("FAIL add_wrap got %h exp 0", dut.rf_q[1]); else pass_cnt++;
    total_cnt++; if (dut.flag_c_q !== 1'b1 || dut.flag_z_q !== 1'b1)
      $display("FAIL add_cz got C=%0b Z=%0b exp 1/1", dut.flag_c_q, dut.flag_z_q); else pass_cnt++;
    tick(4);
    total_cnt++; if (dut.pc_q !== 12'h020 || address !== 12'h020)
      $display("FAIL bra_taken got pc=%h addr=%h exp 020", dut.pc_q, address); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    bit ok;
    restart();
    mem[0] = 32'h5805A001;  // ADD R1,#0x5A
    mem[1] = 32'h20001030;  // STR R1 -> [0x030]
    tick(4);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      ok = (address === 12'h001) && (mem_en === 1'b1) && (rw === 1'b0);
      total_cnt++; if (!ok) $display("FAIL fetch_wait%0d got addr=%h en=%0b rw=%0b exp 001/1/0", i, address, mem_en, rw); else pass_cnt++;
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      ok = (address === 12'h030) && (mem_en === 1'b1) && (rw === 1'b1) && (data_out === 32'h5A) && (wr_count == 0);
      total_cnt++; if (!ok) $display("FAIL mem_wait%0d got addr=%h en=%0b rw=%0b dout=%h wr=%0d exp 030/1/1/5a/0",
                                     i, address, mem_en, rw, data_out, wr_count); else pass_cnt++;
      if (i < 3) tick(1);
    end
    ready = 1'b1;
    tick(2);
    total_cnt++; if (wr_count != 1 || mem[12'h030] !== 32'h5A)
      $display("FAIL str_write got count=%0d data=%h exp 1/5a", wr_count, mem[12'h030]); else pass_cnt++;
    total_cnt++; if (address !== 12'h002 || mem_en !== 1'b1)
      $display("FAIL str_next_fetch got addr=%h en=%0b exp 002/1", address, mem_en); else pass_cnt++;
  endtask

  task automatic test_shift_rotate();
    restart();
    mem[0] = 32'h58001002;  // ADD R2,#1
    mem[1] = 32'h78FFF002;  // SHF R2 by -1
    mem[2] = 32'h58003002;  // ADD R2,#3
    mem[3] = 32'h68FFF002;  // ROT R2 by -1
    mem[4] = 32'h68001002;  // ROT R2 by 1
    tick(8);
    total_cnt++; if (dut.rf_q[2] !== 32'h0 || dut.flag_c_q !== 1'b1)
      $display("FAIL shf_right got R2=%h C=%0b exp 0/1", dut.rf_q[2], dut.flag_c_q); else pass_cnt++;
    tick(8);
    total_cnt++; if (dut.rf_q[2] !== 32'h80000001 || dut.flag_c_q !== 1'b0 || dut.flag_n_q !== 1'b1)
      $display("FAIL rot_right got R2=%h C=%0b N=%0b exp 80000001/0/1", dut.rf_q[2], dut.flag_c_q, dut.flag_n_q); else pass_cnt++;
    tick(4);
    total_cnt++; if (dut.rf_q[2] !== 32'h00000003)
      $display("FAIL rot_left got R2=%h exp 00000003", dut.rf_q[2]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_store();
    restart();
    mem[0]      = 32'h58077005;  // ADD R5,#0x77
    mem[1]      = 32'h20005040;  // STR R5 -> [0x040]
    mem[12'h40] = 32'h0000DEAD;
    tick(5);
    ready = 1'b0;
    tick(2);
    total_cnt++; if (mem_en !== 1'b1 || rw !== 1'b1 || data_out !== 32'h77)
      $display("FAIL abort_pre got en=%0b rw=%0b dout=%h exp 1/1/77", mem_en, rw, data_out); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (mem_en !== 1'b1 || rw !== 1'b0 || address !== 12'h0 || data_out !== 32'h0 || halted !== 1'b0)
      $display("FAIL abort_outputs got en=%0b rw=%0b addr=%h dout=%h halt=%0b exp 1/0/000/0/0",
               mem_en, rw, address, data_out, halted); else pass_cnt++;
    total_cnt++; if (wr_count != 0 || mem[12'h40] !== 32'h0000DEAD)
      $display("FAIL abort_no_write got count=%0d data=%h exp 0/dead", wr_count, mem[12'h40]); else pass_cnt++;
    tick(1);
    reset_n = 1'b1;
    ready   = 1'b1;
    tick(1);
    total_cnt++; if (dut.ir_q !== 32'h58077005 || dut.rf_q[5] !== 32'h0)
      $display("FAIL abort_refetch got ir=%h R5=%h exp 58077005/0", dut.ir_q, dut.rf_q[5]); else pass_cnt++;
  endtask

  task automatic test_wide_config();
    for (int i = 0; i < 256; i++) mem64[i] = 64'h0;
    mem64[0]     = 64'h98000001;  // CMP R1,#0
    mem64[1]     = 64'h58001001;  // ADD R1,#1
    mem64[2]     = 64'h300000FF;  // BRA always -> 0xFF
    mem64[8'hFF] = 64'h00000000;  // NOP
    reset64_n = 1'b1;
    tick(4);
    total_cnt++; if (dut64.rf_q[1] !== 64'hFFFFFFFFFFFFFFFF)
      $display("FAIL w64_cmp got %h exp ffffffffffffffff", dut64.rf_q[1]); else pass_cnt++;
    tick(4);
    total_cnt++; if (dut64.rf_q[1] !== 64'h0 || dut64.flag_c_q !== 1'b1)
      $display("FAIL w64_carry got R1=%h C=%0b exp 0/1", dut64.rf_q[1], dut64.flag_c_q); else pass_cnt++;
    tick(4);
    total_cnt++; if (dut64.pc_q !== 8'hFF || address64 !== 8'hFF)
      $display("FAIL w64_bra got pc=%h addr=%h exp ff", dut64.pc_q, address64); else pass_cnt++;
    tick(4);
    total_cnt++; if (dut64.pc_q !== 8'h00 || address64 !== 8'h00)
      $display("FAIL w64_pc_wrap got pc=%h addr=%h exp 00", dut64.pc_q, address64); else pass_cnt++;
    reset64_n = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) mem64[i] = 64'h0;
    tick(2);
    test_reset();
    test_add_halt();
    test_ld_branch();
    test_wait_states();
    test_shift_rotate();
    test_reset_mid_store();
    test_wide_config();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
